// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for a combinational ADD/NAND ALU. It owns the carry/zero flags
// and runs ADDC as two ALU passes: it adds the operands, then adds the old carry.
module alu_issue_ctrl #(
  parameter int DW = 16,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  // decode side
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  input  logic [TW-1:0] req_tag,
  // ALU side
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_op,
  input  logic [DW-1:0] alu_z,
  input  logic          alu_carry,
  input  logic          alu_zero,
  // writeback side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [TW-1:0] rsp_tag,
  output logic          rsp_we,
  // architectural flags
  output logic          flag_c,
  output logic          flag_z,
  input  logic          flag_clr
);

  localparam logic [1:0] OP_NAND = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_ADDC = 2'b10;
  localparam logic [1:0] OP_CMP  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXEC  = 2'b01,
    PASS2 = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [TW-1:0]   tag_q;
  logic            c1_q;
  logic            accept;

  // A finishing response frees the slot in the same cycle, so a new op can be accepted
  // while the old result is being handed to writeback.
  assign req_ready = (state == IDLE) | ((state == RESP) & rsp_ready);
  assign accept    = req_valid & req_ready;

  // NOTE: all state is registered with non-blocking assignments. Later statements in this
  // block may override earlier ones, and the ordering below relies on that.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= OP_NAND;
      tag_q     <= '0;
      c1_q      <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_we    <= 1'b0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
    end else begin
      // A clear is overridden by a flag capture on the same edge.
      if (flag_clr) begin
        flag_c <= 1'b0;
        flag_z <= 1'b0;
      end

      case (state)
        IDLE: ;
        EXEC: begin
          if (op_q == OP_ADDC) begin
            // Second pass adds the carry held before this ADDC began. The flags stay
            // untouched until the final capture.
            alu_a  <= alu_z;
            alu_b  <= {{(DW-1){1'b0}}, flag_c};
            alu_op <= 1'b1;
            c1_q   <= alu_carry;
            state  <= PASS2;
          end else begin
            rsp_data  <= alu_z;
            rsp_tag   <= tag_q;
            rsp_we    <= (op_q != OP_CMP);
            rsp_valid <= 1'b1;
            flag_c    <= alu_carry;
            flag_z    <= alu_zero;
            state     <= RESP;
          end
        end
        PASS2: begin
          // Both passes together can carry out at most once, so an OR merges them.
          rsp_data  <= alu_z;
          rsp_tag   <= tag_q;
          rsp_we    <= 1'b1;
          rsp_valid <= 1'b1;
          flag_c    <= c1_q | alu_carry;
          flag_z    <= alu_zero;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // An accept in IDLE or on the response handshake overrides the IDLE fallback above.
      if (accept) begin
        op_q   <= req_op;
        tag_q  <= req_tag;
        alu_a  <= req_a;
        alu_b  <= req_b;
        alu_op <= (req_op != OP_NAND);
        state  <= EXEC;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. A behavioural ALU drives the ALU port, and
// results are compared against fixed vectors, hand sequences and a random reference model.
module tb_alu_issue_ctrl;

  localparam int DW = 16;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_op;
  logic [DW-1:0] req_a, req_b;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_a, alu_b, alu_z;
  logic          alu_op, alu_carry, alu_zero;
  logic          rsp_valid, rsp_ready, rsp_we;
  logic [DW-1:0] rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          flag_c, flag_z, flag_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural combinational ALU
  logic [DW:0] alu_sum;
  assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_z     = alu_op ? alu_sum[DW-1:0] : ~(alu_a & alu_b);
  assign alu_carry = alu_op ? alu_sum[DW] : 1'b0;
  assign alu_zero  = (alu_z == '0);

  alu_issue_ctrl #(.DW(DW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_z(alu_z), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_we(rsp_we),
    .flag_c(flag_c), .flag_z(flag_z), .flag_clr(flag_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the whole op as one wide addition (ADDC adds the incoming carry too).
  function automatic void ref_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, output logic [15:0] d, output logic c,
                                 output logic z, output logic we, output int lat);
    logic [16:0] full;
    full = {1'b0, a} + {1'b0, b} + ((op == 2'b10) ? {16'd0, cin} : 17'd0);
    if (op == 2'b00) begin
      d = ~(a & b);
      c = 1'b0;
    end else begin
      d = full[15:0];
      c = full[16];
    end
    z   = (d == 16'd0);
    we  = (op != 2'b11);
    lat = (op == 2'b10) ? 2 : 1;
  endfunction

  // Issue one op, wait for its response, optionally stall writeback, then retire it.
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] tag, input int hold,
                       output logic [15:0] d, output logic [2:0] t, output logic we,
                       output logic c, output logic z, output int lat,
                       output logic aop, output logic [15:0] bp2);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_wait", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; bp2 = '0;
    @(negedge clk);
    aop = alu_op;
    while (!rsp_valid && lat < 10) begin
      if (lat == 1) bp2 = alu_b;
      @(negedge clk);
      lat++;
    end
    d = rsp_data; t = rsp_tag; we = rsp_we; c = flag_c; z = flag_z;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_data", rsp_data, d);
      check("hold_tag_we", {rsp_tag, rsp_we}, {t, we});
      check("hold_req_ready", req_ready, 0);
      check("hold_flags", {flag_c, flag_z}, {c, z});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("flags_after_hs", {flag_c, flag_z}, {c, z});
    check("valid_after_hs", rsp_valid, 0);
  endtask

  task automatic run_check(input string nm, input logic [1:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [2:0] tag, input int hold,
                           input logic [15:0] ed, input logic ewe, input logic ec,
                           input logic ez, input int elat, input logic prev_c);
    logic [15:0] d, bp2;
    logic [2:0]  t;
    logic        we, c, z, aop;
    int          lat;
    do_op(op, a, b, tag, hold, d, t, we, c, z, lat, aop, bp2);
    check({nm, "_data"}, d, ed);
    check({nm, "_tag"}, t, tag);
    check({nm, "_we"}, we, ewe);
    check({nm, "_flags"}, {c, z}, {ec, ez});
    check({nm, "_latency"}, lat, elat);
    check({nm, "_aluop"}, aop, 32'(op != 2'b00));
    if (op == 2'b10) check({nm, "_pass2_b"}, bp2, {15'd0, prev_c});
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [2:0]  tag;
    int          hold;
    logic [15:0] d;
    logic        we, c, z;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic        mc, mz, prev_c, mwe;
    logic [15:0] md;
    int          mlat;

    vecs[0]  = '{2'b01, 16'hFFFF, 16'h0001, 3'd5, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 1};
    vecs[1]  = '{2'b00, 16'hF0F0, 16'hFF00, 3'd1, 0, 16'h0FFF, 1'b1, 1'b0, 1'b0, 1};
    vecs[2]  = '{2'b01, 16'h8000, 16'h8000, 3'd2, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 1};
    vecs[3]  = '{2'b10, 16'h1234, 16'h0001, 3'd3, 0, 16'h1236, 1'b1, 1'b0, 1'b0, 2};
    vecs[4]  = '{2'b01, 16'h8000, 16'h8000, 3'd4, 1, 16'h0000, 1'b1, 1'b1, 1'b1, 1};
    vecs[5]  = '{2'b10, 16'hFFFF, 16'h0000, 3'd6, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 2};
    vecs[6]  = '{2'b11, 16'h0003, 16'h0004, 3'd7, 5, 16'h0007, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{2'b01, 16'h7FFF, 16'h0001, 3'd0, 0, 16'h8000, 1'b1, 1'b0, 1'b0, 1};
    vecs[8]  = '{2'b00, 16'hFFFF, 16'hFFFF, 3'd1, 2, 16'h0000, 1'b1, 1'b0, 1'b1, 1};
    vecs[9]  = '{2'b10, 16'h0001, 16'h0001, 3'd2, 0, 16'h0002, 1'b1, 1'b0, 1'b0, 2};
    vecs[10] = '{2'b01, 16'hFFFE, 16'h0001, 3'd3, 0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    rsp_ready = 1'b0; flag_clr = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp", {rsp_valid, rsp_we, rsp_tag}, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);
    check("rst_flags", {flag_c, flag_z}, 0);
    rst_n = 1'b1;

    // Directed vectors; ADDC pass-2 carry comes from the previous vector's carry
    prev_c = 1'b0;
    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag,
                vecs[i].hold, vecs[i].d, vecs[i].we, vecs[i].c, vecs[i].z, vecs[i].lat, prev_c);
      prev_c = vecs[i].c;
    end

    // Back-to-back: new op accepted on the same edge as the response handshake
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 16'd1; req_b = 16'd2; req_tag = 3'd1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_first_valid", rsp_valid, 1);
    check("b2b_first_data", rsp_data, 16'h0003);
    req_valid = 1'b1; req_a = 16'd5; req_b = 16'd6; req_tag = 3'd2; rsp_ready = 1'b1;
    #1 check("b2b_req_ready", req_ready, 1);
    @(posedge clk);
    #1 begin req_valid = 1'b0; rsp_ready = 1'b0; end
    @(negedge clk);
    check("b2b_exec_valid", rsp_valid, 0);
    check("b2b_exec_alu_a", alu_a, 16'd5);
    @(negedge clk);
    check("b2b_second", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 3'd2, 16'h000B});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // flag_clr alone
    run_check("setflags", 2'b01, 16'hFFFF, 16'h0001, 3'd4, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    @(negedge clk);
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    check("clr_alone", {flag_c, flag_z}, 0);

    // flag_clr coinciding with the capture edge: the capture wins
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b01; req_a = 16'hFFFF; req_b = 16'h0001; req_tag = 3'd6;
    @(posedge clk);
    #1 begin req_valid = 1'b0; flag_clr = 1'b1; end
    @(posedge clk);
    #1 flag_clr = 1'b0;
    @(negedge clk);
    check("clr_vs_capture", {rsp_valid, flag_c, flag_z}, 3'b111);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Asynchronous reset in PASS2 drops the ADDC
    run_check("carry_set", 2'b01, 16'h8000, 16'h8000, 3'd0, 0, 16'h0000, 1'b1, 1'b1, 1'b1, 1, 1'b1);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_a = 16'h0001; req_b = 16'h0002; req_tag = 3'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pass2_alu_b", alu_b, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rstmid_valid", rsp_valid, 0);
    check("rstmid_flags", {flag_c, flag_z}, 0);
    check("rstmid_req_ready", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rstmid_no_rsp", rsp_valid, 0);
    end
    run_check("after_rst", 2'b01, 16'h0001, 16'h0001, 3'd5, 0, 16'h0002, 1'b1, 1'b0, 1'b0, 1, 1'b0);

    // Random ops against the reference model
    mc = 1'b0; mz = 1'b0;
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [15:0] a, b;
      logic [2:0]  tag;
      op  = 2'($urandom_range(0, 3));
      a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 16'(0 - a) : 16'($urandom);
      tag = 3'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        mc = 1'b0; mz = 1'b0;
        check("rnd_clr", {flag_c, flag_z}, 0);
      end
      prev_c = mc;
      ref_op(op, a, b, mc, md, mc, mz, mwe, mlat);
      run_check($sformatf("rnd%0d", i), op, a, b, tag, $urandom_range(0, 3), md, mwe, mc, mz,
                mlat, prev_c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
